// File: rtl/wb_dest_pipe_pkg.sv
// -----------------------------------------------------------------------------
// wb_dest_pipe_pkg
// Shared definitions for the writeback-destination pipeline:
//   - register-address / writeback-select widths
//   - writeback-select (WS) encodings
//   - stage write-tag struct {valid, wa, we, ws}
//   - ID/EX next-value select used between hazard_detect and the stage regs
// -----------------------------------------------------------------------------
package wb_dest_pipe_pkg;

    localparam int AW = 5;
    localparam int SW = 3;

    localparam logic [SW-1:0] WS_ALU  = 3'd0;
    localparam logic [SW-1:0] WS_HILO = 3'd1;
    localparam logic [SW-1:0] WS_PC8  = 3'd2;
    localparam logic [SW-1:0] WS_LOAD = 3'd3;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] wa;
        logic          we;
        logic [SW-1:0] ws;
    } stage_tag_t;

    // What the ID/EX register takes on the next edge.
    typedef enum logic [1:0] {
        IDEX_LOAD   = 2'd0,
        IDEX_HOLD   = 2'd1,
        IDEX_BUBBLE = 2'd2
    } idex_sel_t;

    // A tag only writes the register file when it is a real instruction
    // with write enable set and a non-zero destination.
    function automatic logic tag_writes(input stage_tag_t t);
        return t.valid & t.we & (t.wa != '0);
    endfunction

endpackage

// File: rtl/wb_dest_pipe_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detection and front-end control resolution.
// Priority per cycle: ex_hold > ex_flush > load_use > normal.
//
// Ports:
//   idex_valid/we/ws/wa      in   instruction currently in EX (ID/EX register)
//   id_valid, id_ra1/2,
//   id_use1/2                in   instruction currently in decode
//   ex_hold, ex_flush        in   EX-stage hold / redirect requests
//   load_use                 out  raw load-use condition (before priority)
//   stall_if, stall_id       out  hold PC / hold IF/ID
//   flush_id                 out  squash IF/ID
//   idex_sel                 out  ID/EX next-value select (load/hold/bubble)
//   exmem_bubble             out  EX/MEM loads a bubble instead of ID/EX
// -----------------------------------------------------------------------------
module hazard_detect
    import wb_dest_pipe_pkg::*;
#(
    parameter int             AW      = wb_dest_pipe_pkg::AW,
    parameter int             SW      = wb_dest_pipe_pkg::SW,
    parameter logic [SW-1:0]  WS_LOAD = wb_dest_pipe_pkg::WS_LOAD
) (
    input  logic          idex_valid,
    input  logic          idex_we,
    input  logic [SW-1:0] idex_ws,
    input  logic [AW-1:0] idex_wa,
    input  logic          id_valid,
    input  logic [AW-1:0] id_ra1,
    input  logic [AW-1:0] id_ra2,
    input  logic          id_use1,
    input  logic          id_use2,
    input  logic          ex_hold,
    input  logic          ex_flush,
    output logic          load_use,
    output logic          stall_if,
    output logic          stall_id,
    output logic          flush_id,
    output idex_sel_t     idex_sel,
    output logic          exmem_bubble
);

    logic ex_is_load;
    logic src_match;

    // Load data only exists at MEM/WB, so a dependent instruction in decode
    // cannot be covered by forwarding while the load sits in EX.
    assign ex_is_load = idex_valid & idex_we & (idex_ws == WS_LOAD) & (idex_wa != '0);
    assign src_match  = (id_use1 & (id_ra1 == idex_wa)) | (id_use2 & (id_ra2 == idex_wa));
    assign load_use   = ex_is_load & id_valid & src_match;

    always_comb begin
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        flush_id     = 1'b0;
        idex_sel     = IDEX_LOAD;
        exmem_bubble = 1'b0;

        if (ex_hold) begin
            // EX instruction stays put; downstream drains behind a bubble.
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            idex_sel     = IDEX_HOLD;
            exmem_bubble = 1'b1;
        end else if (ex_flush) begin
            // Decode instruction is on the wrong path, so its hazard is moot.
            flush_id = 1'b1;
            idex_sel = IDEX_BUBBLE;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            idex_sel = IDEX_BUBBLE;
        end
    end

endmodule

// File: rtl/wb_dest_pipe.sv
// -----------------------------------------------------------------------------
// wb_dest_pipe
// Carries each instruction's writeback destination through ID/EX, EX/MEM and
// MEM/WB, drives the EX/MEM and MEM/WB write tags for the forwarding unit and
// the register-file write port, and generates load-use stall / flush controls.
//
// Ports:
//   clk, rst_n                      clock (rising), async active-low reset
//   id_valid, id_ra1, id_ra2,
//   id_use1, id_use2, id_wa,
//   id_we, id_ws                    decode-stage instruction fields
//   ex_hold, ex_flush               EX busy / taken-branch redirect
//   ra1_ex, ra2_ex                  sources of the EX instruction
//   wa_em, we_em, ws_em             EX/MEM write tag
//   wa_mw, we_mw, ws_mw             MEM/WB write tag (register-file write)
//   stall_if, stall_id, flush_id    front-end controls
//   stall_cnt                       saturating count of stall_if cycles
// -----------------------------------------------------------------------------
module wb_dest_pipe
    import wb_dest_pipe_pkg::*;
#(
    parameter int             AW      = wb_dest_pipe_pkg::AW,
    parameter int             SW      = wb_dest_pipe_pkg::SW,
    parameter logic [SW-1:0]  WS_LOAD = wb_dest_pipe_pkg::WS_LOAD,
    parameter int             CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_ra1,
    input  logic [AW-1:0]    id_ra2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [AW-1:0]    id_wa,
    input  logic             id_we,
    input  logic [SW-1:0]    id_ws,
    input  logic             ex_hold,
    input  logic             ex_flush,
    output logic [AW-1:0]    ra1_ex,
    output logic [AW-1:0]    ra2_ex,
    output logic [AW-1:0]    wa_em,
    output logic             we_em,
    output logic [SW-1:0]    ws_em,
    output logic [AW-1:0]    wa_mw,
    output logic             we_mw,
    output logic [SW-1:0]    ws_mw,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic [CNT_W-1:0] stall_cnt
);

    // Widths follow the module parameters so overrides stay consistent.
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [AW-1:0] wa;
        logic          we;
        logic [SW-1:0] ws;
    } idex_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] wa;
        logic          we;
        logic [SW-1:0] ws;
    } tag_t;

    idex_t     idex_q;
    tag_t      exmem_q;
    tag_t      memwb_q;
    idex_sel_t idex_sel;
    logic      exmem_bubble;
    logic      load_use;

    hazard_detect #(
        .AW      (AW),
        .SW      (SW),
        .WS_LOAD (WS_LOAD)
    ) u_hazard_detect (
        .idex_valid   (idex_q.valid),
        .idex_we      (idex_q.we),
        .idex_ws      (idex_q.ws),
        .idex_wa      (idex_q.wa),
        .id_valid     (id_valid),
        .id_ra1       (id_ra1),
        .id_ra2       (id_ra2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .ex_hold      (ex_hold),
        .ex_flush     (ex_flush),
        .load_use     (load_use),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush_id     (flush_id),
        .idex_sel     (idex_sel),
        .exmem_bubble (exmem_bubble)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            case (idex_sel)
                IDEX_LOAD: begin
                    idex_q.valid <= id_valid;
                    idex_q.ra1   <= id_ra1;
                    idex_q.ra2   <= id_ra2;
                    idex_q.wa    <= id_wa;
                    idex_q.we    <= id_we;
                    idex_q.ws    <= id_ws;
                end
                IDEX_HOLD:   idex_q <= idex_q;
                // A bubble clears every field so nothing stale reaches fwd.
                IDEX_BUBBLE: idex_q <= '0;
                default:     idex_q <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            if (exmem_bubble) begin
                exmem_q <= '0;
            end else begin
                exmem_q.valid <= idex_q.valid;
                exmem_q.wa    <= idex_q.wa;
                exmem_q.we    <= idex_q.we;
                exmem_q.ws    <= idex_q.ws;
            end
            memwb_q <= exmem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_if && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ra1_ex = idex_q.ra1;
    assign ra2_ex = idex_q.ra2;

    assign wa_em = exmem_q.wa;
    assign ws_em = exmem_q.ws;
    assign we_em = exmem_q.valid & exmem_q.we & (exmem_q.wa != '0);

    assign wa_mw = memwb_q.wa;
    assign ws_mw = memwb_q.ws;
    assign we_mw = memwb_q.valid & memwb_q.we & (memwb_q.wa != '0);

endmodule

// File: tb/tb_wb_dest_pipe.sv
module tb_wb_dest_pipe;
    import wb_dest_pipe_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_use1, id_use2, id_we, ex_hold, ex_flush;
    logic [AW-1:0] id_ra1, id_ra2, id_wa;
    logic [SW-1:0] id_ws;

    logic [AW-1:0] ra1_ex, ra2_ex, wa_em, wa_mw;
    logic          we_em, we_mw, stall_if, stall_id, flush_id;
    logic [SW-1:0] ws_em, ws_mw;
    logic [15:0]   stall_cnt;

    logic [AW-1:0] s_ra1_ex, s_ra2_ex, s_wa_em, s_wa_mw;
    logic          s_we_em, s_we_mw, s_stall_if, s_stall_id, s_flush_id;
    logic [SW-1:0] s_ws_em, s_ws_mw;
    logic [3:0]    s_stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    wb_dest_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wa(id_wa), .id_we(id_we), .id_ws(id_ws),
        .ex_hold(ex_hold), .ex_flush(ex_flush), .ra1_ex(ra1_ex), .ra2_ex(ra2_ex),
        .wa_em(wa_em), .we_em(we_em), .ws_em(ws_em), .wa_mw(wa_mw), .we_mw(we_mw),
        .ws_mw(ws_mw), .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy sharing all stimulus, used for saturation.
    wb_dest_pipe #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wa(id_wa), .id_we(id_we), .id_ws(id_ws),
        .ex_hold(ex_hold), .ex_flush(ex_flush), .ra1_ex(s_ra1_ex), .ra2_ex(s_ra2_ex),
        .wa_em(s_wa_em), .we_em(s_we_em), .ws_em(s_ws_em), .wa_mw(s_wa_mw), .we_mw(s_we_mw),
        .ws_mw(s_ws_mw), .stall_if(s_stall_if), .stall_id(s_stall_id), .flush_id(s_flush_id),
        .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic          valid;
        logic [AW-1:0] wa;
        logic          we;
        logic [SW-1:0] ws;
        logic          exp_we;
    } vec_t;

    typedef struct {
        logic [AW-1:0] wa;
        logic          we;
        logic [SW-1:0] ws;
    } exp_tag_t;

    vec_t     vecs[8];
    exp_tag_t q_em[$];
    exp_tag_t q_mw[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        id_valid = 0; id_ra1 = 0; id_ra2 = 0; id_use1 = 0; id_use2 = 0;
        id_wa = 0; id_we = 0; id_ws = 0;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] wa, input logic we,
                         input logic [SW-1:0] ws, input logic [AW-1:0] r1, input logic u1,
                         input logic [AW-1:0] r2, input logic u2);
        id_valid = v; id_wa = wa; id_we = we; id_ws = ws;
        id_ra1 = r1; id_use1 = u1; id_ra2 = r2; id_use2 = u2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_tag_t e;
        rst_n = 0; ex_hold = 0; ex_flush = 0;
        drive_idle();

        vecs[0] = '{1'b1, 5'd5,  1'b1, WS_ALU,  1'b1};
        vecs[1] = '{1'b1, 5'd6,  1'b1, WS_HILO, 1'b1};
        vecs[2] = '{1'b1, 5'd0,  1'b1, WS_ALU,  1'b0};
        vecs[3] = '{1'b0, 5'd7,  1'b1, WS_ALU,  1'b0};
        vecs[4] = '{1'b1, 5'd31, 1'b1, WS_PC8,  1'b1};
        vecs[5] = '{1'b1, 5'd9,  1'b0, WS_ALU,  1'b0};
        vecs[6] = '{1'b1, 5'd10, 1'b1, WS_LOAD, 1'b1};
        vecs[7] = '{1'b1, 5'd12, 1'b1, WS_ALU,  1'b1};

        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("rst_we_em", we_em, 0);
        check("rst_we_mw", we_mw, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_stall_if", stall_if, 0);
        check("rst_stall_id", stall_id, 0);
        check("rst_flush_id", flush_id, 0);

        // Back-to-back stream, no hazards: tags emerge on EX/MEM after 2 edges
        // and on MEM/WB after 3.
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                drive(vecs[i].valid, vecs[i].wa, vecs[i].we, vecs[i].ws, 0, 0, 0, 0);
                e = '{vecs[i].wa, vecs[i].exp_we, vecs[i].ws};
            end else begin
                drive_idle();
                e = '{5'd0, 1'b0, 3'd0};
            end
            q_em.push_back(e);
            q_mw.push_back(e);
            #1 check("stream_stall_if", stall_if, 0);
            @(negedge clk);
            if (i + 1 >= 2) begin
                e = q_em.pop_front();
                check("stream_wa_em", wa_em, e.wa);
                check("stream_we_em", we_em, e.we);
                check("stream_ws_em", ws_em, e.ws);
            end
            if (i + 1 >= 3) begin
                e = q_mw.pop_front();
                check("stream_wa_mw", wa_mw, e.wa);
                check("stream_we_mw", we_mw, e.we);
                check("stream_ws_mw", ws_mw, e.ws);
            end
        end
        check("stream_stall_cnt", stall_cnt, exp_cnt);

        // Load-use: exactly one stall cycle with a bubble into ID/EX.
        drive(1, 8, 1, WS_LOAD, 7, 0, 0, 0);
        @(negedge clk);
        drive(1, 9, 1, WS_ALU, 8, 1, 2, 1);
        #1;
        check("lu_stall_if", stall_if, 1);
        check("lu_stall_id", stall_id, 1);
        check("lu_flush_id", flush_id, 0);
        exp_cnt++;
        @(negedge clk);
        check("lu_bubble_ra1_ex", ra1_ex, 0);
        check("lu_wa_em", wa_em, 8);
        check("lu_we_em", we_em, 1);
        check("lu_ws_em", ws_em, WS_LOAD);
        check("lu_stall_cnt", stall_cnt, exp_cnt);
        #1 check("lu_one_cycle", stall_if, 0);
        @(negedge clk);
        check("lu_ra1_ex", ra1_ex, 8);
        check("lu_wa_mw", wa_mw, 8);
        check("lu_we_mw", we_mw, 1);
        drive_idle();
        @(negedge clk);

        // use2 gating, then register 0 never hazards or writes.
        drive(1, 8, 1, WS_LOAD, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 4, 1, WS_ALU, 3, 1, 8, 0);
        #1 check("use2_gate_stall", stall_if, 0);
        @(negedge clk);
        drive(1, 0, 1, WS_LOAD, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 4, 1, WS_ALU, 0, 1, 0, 1);
        #1 check("r0_stall", stall_if, 0);
        @(negedge clk);
        check("r0_we_em", we_em, 0);
        check("r0_wa_em", wa_em, 0);
        drive_idle();
        @(negedge clk);
        check("r0_we_mw", we_mw, 0);
        check("gate_stall_cnt", stall_cnt, exp_cnt);

        // Flush beats load_use.
        drive(1, 8, 1, WS_LOAD, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 9, 1, WS_ALU, 8, 1, 4, 1);
        ex_flush = 1;
        #1;
        check("fl_flush_id", flush_id, 1);
        check("fl_stall_if", stall_if, 0);
        check("fl_stall_id", stall_id, 0);
        @(negedge clk);
        ex_flush = 0;
        drive_idle();
        check("fl_bubble_ra1", ra1_ex, 0);
        check("fl_bubble_ra2", ra2_ex, 0);
        check("fl_wa_em", wa_em, 8);
        check("fl_stall_cnt", stall_cnt, exp_cnt);

        // ex_hold for 3 cycles over a pending load_use, then one extra stall.
        drive(1, 8, 1, WS_LOAD, 7, 0, 0, 0);
        @(negedge clk);
        drive(1, 9, 1, WS_ALU, 8, 1, 0, 0);
        ex_hold = 1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) ex_flush = 1;
            #1;
            check("hold_stall_if", stall_if, 1);
            check("hold_stall_id", stall_id, 1);
            check("hold_flush_id", flush_id, 0);
            exp_cnt++;
            @(negedge clk);
            ex_flush = 0;
            check("hold_ra1_ex", ra1_ex, 7);
            check("hold_we_em", we_em, 0);
            if (k == 2) ex_hold = 0;
        end
        #1 check("hold_release_stall", stall_if, 1);
        exp_cnt++;
        @(negedge clk);
        check("hold_wa_em", wa_em, 8);
        check("hold_we_em_load", we_em, 1);
        check("hold_stall_cnt", stall_cnt, exp_cnt);
        #1 check("hold_done", stall_if, 0);
        @(negedge clk);
        check("hold_ra1_consumer", ra1_ex, 8);
        drive_idle();
        @(negedge clk);

        // Saturation on the 4-bit counter.
        ex_hold = 1;
        repeat (10) @(negedge clk);
        exp_cnt += 10;
        check("sat_small_mid", s_stall_cnt, (exp_cnt > 15) ? 15 : exp_cnt);
        repeat (10) @(negedge clk);
        exp_cnt += 10;
        ex_hold = 0;
        check("sat_small", s_stall_cnt, 15);
        check("sat_big", stall_cnt, exp_cnt);
        @(negedge clk);

        // Reset while stalling: controls drop without a clock edge.
        drive(1, 8, 1, WS_LOAD, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 9, 1, WS_ALU, 8, 1, 0, 0);
        #1 check("mid_stall_pre", stall_if, 1);
        #1 rst_n = 0;
        #1;
        check("mid_rst_stall_if", stall_if, 0);
        check("mid_rst_stall_id", stall_id, 0);
        check("mid_rst_ra1_ex", ra1_ex, 0);
        check("mid_rst_we_em", we_em, 0);
        check("mid_rst_we_mw", we_mw, 0);
        check("mid_rst_cnt", stall_cnt, 0);
        @(negedge clk);
        drive_idle();
        rst_n = 1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
